// File: rtl/ext_int_ctrl_if.sv
// Signal bundle between the external interrupt controller and its peripherals/CPU.
// The slave side is the controller; the master side drives requests, mask, reti and clr_status.
interface ext_int_ctrl_if;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       reti;
  logic       clr_status;
  logic       ext_int1;
  logic       ext_int2;
  logic       ext_int3;
  logic       ext_int4;
  logic [3:0] pending;
  logic [2:0] active_id;
  logic [7:0] overrun_cnt;
  logic       ack_timeout;

  modport master (
    output irq_in, irq_mask, reti, clr_status,
    input  ext_int1, ext_int2, ext_int3, ext_int4,
    input  pending, active_id, overrun_cnt, ack_timeout
  );

  modport slave (
    input  irq_in, irq_mask, reti, clr_status,
    output ext_int1, ext_int2, ext_int3, ext_int4,
    output pending, active_id, overrun_cnt, ack_timeout
  );
endinterface

// File: rtl/ext_int_ctrl.sv
// External interrupt controller: latches rising edges on four request lines and issues
// them one at a time to the CPU in fixed priority, waiting for reti (or a timeout) in between.
module ext_int_ctrl #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2,
  parameter logic [23:0] ACK_TIMEOUT  = 24'd1000000
) (
  input  logic          clk,
  input  logic          reset,
  ext_int_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_ACK, GAP} state_t;

  localparam logic [3:0] PULSE_INIT = 4'(PULSE_CYCLES - 1);
  localparam logic [3:0] GAP_INIT   = 4'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  irq_prev;
  logic [3:0]  pending;
  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [3:0]  grant_mask;
  logic [3:0]  clr_mask;
  logic [3:0]  lost;
  logic [2:0]  grant_id;
  logic [2:0]  active_id;
  logic [3:0]  pulse_cnt;
  logic [3:0]  gap_cnt;
  logic [23:0] to_cnt;
  logic [7:0]  overrun_cnt;
  logic [2:0]  ov_inc;
  logic [8:0]  ov_sum;
  logic        ack_timeout;
  logic        grant;
  logic        timeout_hit;

  assign rise     = bus.irq_in & ~irq_prev;
  assign eligible = pending & ~bus.irq_mask;

  // Source 1 (bit 0) has the highest priority.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_id   = 3'd0;
    grant_mask = 4'b0000;
    if (eligible[0]) begin
      grant_id   = 3'd1;
      grant_mask = 4'b0001;
    end else if (eligible[1]) begin
      grant_id   = 3'd2;
      grant_mask = 4'b0010;
    end else if (eligible[2]) begin
      grant_id   = 3'd3;
      grant_mask = 4'b0100;
    end else if (eligible[3]) begin
      grant_id   = 3'd4;
      grant_mask = 4'b1000;
    end
  end

  // A rise landing on the same edge as its own grant-clear re-arms the bit and is not lost.
  assign clr_mask = grant ? grant_mask : 4'b0000;
  assign lost     = rise & pending & ~clr_mask;
  assign ov_inc   = 3'({2'b00, lost[0]}) + 3'({2'b00, lost[1]})
                  + 3'({2'b00, lost[2]}) + 3'({2'b00, lost[3]});
  assign ov_sum   = {1'b0, overrun_cnt} + {6'd0, ov_inc};

  always_comb begin
    state_nxt   = state;
    grant       = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          grant     = 1'b1;
          state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (pulse_cnt == 4'd0) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (bus.reti) begin
          state_nxt = GAP;
        end else if (to_cnt == ACK_TIMEOUT - 24'd1) begin
          timeout_hit = 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: reset is asynchronous, so it sits in the sensitivity list and clears without a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev    <= 4'b0000;
      pending     <= 4'b0000;
      overrun_cnt <= 8'd0;
      ack_timeout <= 1'b0;
    end else begin
      irq_prev <= bus.irq_in;
      pending  <= (pending & ~clr_mask) | rise;

      if (bus.clr_status)       overrun_cnt <= 8'd0;
      else if (ov_sum > 9'd255) overrun_cnt <= 8'hff;
      else                      overrun_cnt <= ov_sum[7:0];

      // Set wins over clear so a timeout coinciding with clr_status is never missed.
      if (timeout_hit)         ack_timeout <= 1'b1;
      else if (bus.clr_status) ack_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_id <= 3'd0;
      pulse_cnt <= 4'd0;
      gap_cnt   <= 4'd0;
      to_cnt    <= 24'd0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            active_id <= grant_id;
            pulse_cnt <= PULSE_INIT;
          end
        end
        PULSE: begin
          if (pulse_cnt != 4'd0) pulse_cnt <= pulse_cnt - 4'd1;
          else                   to_cnt    <= 24'd0;
        end
        WAIT_ACK: begin
          to_cnt <= to_cnt + 24'd1;
          if (state_nxt == GAP) begin
            active_id <= 3'd0;
            gap_cnt   <= GAP_INIT;
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.ext_int1    = (state == PULSE) && (active_id == 3'd1);
  assign bus.ext_int2    = (state == PULSE) && (active_id == 3'd2);
  assign bus.ext_int3    = (state == PULSE) && (active_id == 3'd3);
  assign bus.ext_int4    = (state == PULSE) && (active_id == 3'd4);
  assign bus.pending     = pending;
  assign bus.active_id   = active_id;
  assign bus.overrun_cnt = overrun_cnt;
  assign bus.ack_timeout = ack_timeout;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Bench for ext_int_ctrl: directed stimulus pushes expected grants into a queue that a
// negedge monitor pops on each new ext_int rise; register-level values are checked inline.
module tb_ext_int_ctrl;

  localparam int unsigned PULSE = 2;
  localparam int unsigned GAPC  = 2;
  localparam int unsigned TMO   = 20;

  logic clk;
  logic reset;

  ext_int_ctrl_if bus ();

  ext_int_ctrl #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAPC),
    .ACK_TIMEOUT (24'(TMO))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int exp_q[$];

  task automatic check(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int ext_vec();
    return int'({bus.ext_int4, bus.ext_int3, bus.ext_int2, bus.ext_int1});
  endfunction

  // One-cycle request pulse followed by one low cycle; returns at the negedge after the low cycle.
  task automatic pulse_irq(input logic [3:0] bits);
    bus.irq_in = bits;
    cyc(1);
    bus.irq_in = 4'b0000;
    cyc(1);
  endtask

  // Called at the negedge just after a grant edge: finish the pulse, acknowledge, sit out the gap.
  task automatic serve_and_ack();
    cyc(PULSE);
    check("ext_low_in_wait_ack", ext_vec(), 0);
    bus.reti = 1'b1;
    cyc(1);
    bus.reti = 1'b0;
    check("active_cleared_after_reti", int'(bus.active_id), 0);
    cyc(GAPC);
  endtask

  // Monitor: a new ext_int rise must match the head of the expected-grant queue.
  logic [3:0] mon_prev;
  int         mon_width;
  always @(negedge clk) begin
    logic [3:0] cur;
    int         exp_id;
    cur = 4'(ext_vec());
    if (reset) begin
      mon_prev  = 4'b0000;
      mon_width = 0;
    end else begin
      if ((cur & ~mon_prev) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", int'(cur), 0);
        end else begin
          exp_id = exp_q.pop_front();
          check("grant_id", int'(bus.active_id), exp_id);
          check("grant_line_onehot", int'(cur), 1 << (exp_id - 1));
        end
      end
      if (cur != 4'b0000) begin
        mon_width++;
      end else if (mon_prev != 4'b0000) begin
        check("pulse_width", mon_width, int'(PULSE));
        mon_width = 0;
      end
      mon_prev = cur;
    end
  end

  initial begin
    reset          = 1'b1;
    bus.irq_in     = 4'b0000;
    bus.irq_mask   = 4'b0000;
    bus.reti       = 1'b0;
    bus.clr_status = 1'b0;
    cyc(2);
    check("rst_ext", ext_vec(), 0);
    check("rst_pending", int'(bus.pending), 0);
    check("rst_active", int'(bus.active_id), 0);
    check("rst_overrun", int'(bus.overrun_cnt), 0);
    check("rst_ack_timeout", int'(bus.ack_timeout), 0);
    reset = 1'b0;
    cyc(2);

    // Single request on source 3.
    exp_q.push_back(3);
    bus.irq_in = 4'b0100;
    cyc(1);
    bus.irq_in = 4'b0000;
    check("single_pending", int'(bus.pending), 4'b0100);
    check("single_not_yet_granted", ext_vec(), 0);
    cyc(1);
    check("single_active", int'(bus.active_id), 3);
    check("single_ext3", int'(bus.ext_int3), 1);
    check("single_pending_cleared", int'(bus.pending), 0);
    serve_and_ack();

    // Priority: sources 2 and 4 together, 2 first.
    exp_q.push_back(2);
    exp_q.push_back(4);
    bus.irq_in = 4'b1010;
    cyc(1);
    bus.irq_in = 4'b0000;
    check("prio_pending_both", int'(bus.pending), 4'b1010);
    cyc(1);
    check("prio_first_active", int'(bus.active_id), 2);
    check("prio_pending_rest", int'(bus.pending), 4'b1000);
    cyc(PULSE);
    bus.reti = 1'b1;
    cyc(1);
    bus.reti = 1'b0;
    check("prio_gap_active", int'(bus.active_id), 0);
    cyc(GAPC);
    check("prio_still_pending", int'(bus.pending), 4'b1000);
    check("prio_no_grant_in_gap", ext_vec(), 0);
    cyc(1);
    check("prio_second_active", int'(bus.active_id), 4);
    check("prio_pending_empty", int'(bus.pending), 0);
    serve_and_ack();

    // Overrun counting, saturation and clear on masked source 1.
    bus.irq_mask = 4'b0001;
    pulse_irq(4'b0001);
    check("ovr_pending", int'(bus.pending), 4'b0001);
    for (int i = 0; i < 3; i++) pulse_irq(4'b0001);
    check("ovr_three", int'(bus.overrun_cnt), 3);
    for (int i = 0; i < 252; i++) pulse_irq(4'b0001);
    check("ovr_at_255", int'(bus.overrun_cnt), 255);
    for (int i = 0; i < 8; i++) pulse_irq(4'b0001);
    check("ovr_saturated", int'(bus.overrun_cnt), 255);
    bus.clr_status = 1'b1;
    cyc(1);
    bus.clr_status = 1'b0;
    check("ovr_cleared", int'(bus.overrun_cnt), 0);
    bus.irq_in     = 4'b0001;
    bus.clr_status = 1'b1;
    cyc(1);
    bus.irq_in     = 4'b0000;
    bus.clr_status = 1'b0;
    check("ovr_clear_wins", int'(bus.overrun_cnt), 0);
    check("ovr_masked_no_grant", int'(bus.active_id), 0);
    exp_q.push_back(1);
    bus.irq_mask = 4'b0000;
    cyc(1);
    check("ovr_unmask_grant", int'(bus.active_id), 1);
    serve_and_ack();

    // Mask holds source 2 for 100 cycles; unmasking grants on the next edge.
    bus.irq_mask = 4'b0010;
    pulse_irq(4'b0010);
    cyc(100);
    check("mask_held_pending", int'(bus.pending), 4'b0010);
    check("mask_held_idle", int'(bus.active_id), 0);
    exp_q.push_back(2);
    bus.irq_mask = 4'b0000;
    cyc(1);
    check("mask_release_grant", int'(bus.active_id), 2);
    serve_and_ack();

    // Grant-clear and a fresh rise on source 3 in the same cycle.
    bus.irq_mask = 4'b0100;
    pulse_irq(4'b0100);
    exp_q.push_back(3);
    exp_q.push_back(3);
    bus.irq_mask = 4'b0000;
    bus.irq_in   = 4'b0100;
    cyc(1);
    bus.irq_in = 4'b0000;
    check("coincide_active", int'(bus.active_id), 3);
    check("coincide_pending_kept", int'(bus.pending), 4'b0100);
    check("coincide_no_overrun", int'(bus.overrun_cnt), 0);
    serve_and_ack();
    cyc(1);
    check("coincide_regrant", int'(bus.active_id), 3);
    check("coincide_pending_empty", int'(bus.pending), 0);
    serve_and_ack();

    // Timeout on source 1 with source 4 queued; clr_status collides with the timeout.
    exp_q.push_back(1);
    exp_q.push_back(4);
    pulse_irq(4'b1001);
    check("tmo_active", int'(bus.active_id), 1);
    check("tmo_queued", int'(bus.pending), 4'b1000);
    cyc(PULSE);
    cyc(TMO - 1);
    check("tmo_not_yet", int'(bus.ack_timeout), 0);
    check("tmo_still_active", int'(bus.active_id), 1);
    bus.clr_status = 1'b1;
    cyc(1);
    bus.clr_status = 1'b0;
    check("tmo_flag_set_wins", int'(bus.ack_timeout), 1);
    check("tmo_active_cleared", int'(bus.active_id), 0);
    cyc(GAPC + 1);
    check("tmo_next_served", int'(bus.active_id), 4);
    serve_and_ack();
    bus.clr_status = 1'b1;
    cyc(1);
    bus.clr_status = 1'b0;
    check("tmo_flag_cleared", int'(bus.ack_timeout), 0);

    // Asynchronous reset in the middle of a pulse, with another source pending.
    exp_q.push_back(2);
    pulse_irq(4'b0110);
    check("rstmid_ext2", int'(bus.ext_int2), 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_ext", ext_vec(), 0);
    check("rstmid_active", int'(bus.active_id), 0);
    check("rstmid_pending", int'(bus.pending), 0);
    check("rstmid_overrun", int'(bus.overrun_cnt), 0);
    check("rstmid_ack_timeout", int'(bus.ack_timeout), 0);
    cyc(2);
    reset = 1'b0;
    cyc(20);
    check("rstmid_no_stale_ext", ext_vec(), 0);
    check("rstmid_no_stale_active", int'(bus.active_id), 0);
    check("rstmid_no_stale_pending", int'(bus.pending), 0);

    cyc(2);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ext_int_ctrl.md
# ext_int_ctrl

External interrupt controller that sits between peripherals and the CPU program-counter block. It captures rising edges on four peripheral request lines and holds each as pending. It then issues one interrupt at a time on the CPU's `ext_int1`..`ext_int4` lines, in fixed priority, and waits for the CPU's return-from-interrupt before issuing the next. It also reports pending state, the active source, overruns and acknowledge timeouts.

## Interface

Parameters:
- `PULSE_CYCLES`, default 2: number of cycles an `ext_intN` output is held high; legal range 2..15.
- `GAP_CYCLES`, default 2: number of low cycles enforced after an acknowledge before the next grant; legal range 1..15.
- `ACK_TIMEOUT`, default 24'd1000000: number of cycles to wait for `reti` before abandoning the grant; legal range 1..2^24-1.

Ports:
- `clk`  in  1  system clock; all logic is clocked on the posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_in`  in  4  peripheral requests, synchronous to `clk`; bit 0 maps to source 1.
- `irq_mask`  in  4  1 = source masked; its pending bit is retained but never granted.
- `reti`  in  1  one-cycle pulse when the CPU executes reti.
- `clr_status`  in  1  clears `overrun_cnt` and `ack_timeout`.
- `ext_int1`..`ext_int4`  out  1 each  interrupt lines to the CPU.
- `pending`  out  4  latched, not-yet-granted requests.
- `active_id`  out  3  source being served: 0 = none, 1..4 = source.
- `overrun_cnt`  out  8  saturating count of lost requests.
- `ack_timeout`  out  1  sticky flag, set when `reti` did not arrive within `ACK_TIMEOUT`.

## Operation

- Edge detect:
  - `irq_prev` is registered from `irq_in`.
  - A rise on bit i is `irq_in[i] & ~irq_prev[i]`; it sets `pending[i]`.
  - A rise on a source whose pending bit is already set increments `overrun_cnt`, saturating at 255.
- FSM states: IDLE, PULSE, WAIT_ACK, GAP.
- IDLE:
  - If `pending & ~irq_mask` is nonzero, grant the lowest index (source 1 highest).
  - On grant: clear that pending bit, set `active_id`, load the pulse counter and go to PULSE.
- PULSE:
  - `ext_int<active_id>` is high; all other `ext_int` outputs are low.
  - After `PULSE_CYCLES` cycles, drop the line, clear the timeout counter and go to WAIT_ACK.
- WAIT_ACK:
  - On `reti`, go to GAP.
  - Otherwise, when the 24-bit timeout counter reaches `ACK_TIMEOUT`, set `ack_timeout` and go to GAP.
- GAP:
  - `active_id` becomes 0 on entry.
  - After `GAP_CYCLES` cycles, go to IDLE.
- `reti` outside WAIT_ACK is ignored.
- Simultaneous events:
  - A grant-clear and a new rise on the same source in the same cycle leave the pending bit set and do not count as an overrun.
  - `clr_status` together with an overrun event clears the count to 0; clear wins.
  - `clr_status` together with a timeout leaves `ack_timeout` set; set wins.
- Masking a source while it is being served does not abort the grant.
- Reset mid-operation: state returns to IDLE immediately, and every output and internal register is cleared.

## Timing

- Reset values:
  - `ext_int1..4` = 0, `pending` = 0, `active_id` = 0, `overrun_cnt` = 0, `ack_timeout` = 0, `irq_prev` = 0, FSM = IDLE.
- Latency:
  - `irq_in[i]` first sampled high at edge t: `pending[i]` is 1 after edge t.
  - If the FSM is idle and the source is unmasked, `ext_int` is high after edge t+1.
  - Total latency is 2 cycles.
- Pulse: the line is high for exactly `PULSE_CYCLES` cycles; the minimum of 2 guarantees sampling by the CPU's negedge edge detector.
- A granted source's `ext_int` line does not rise again until at least `PULSE_CYCLES` + 1 (WAIT_ACK) + `GAP_CYCLES` cycles after its previous rise.
- At most one `ext_int` output is high in any cycle.
- Timeout: `ack_timeout` rises `ACK_TIMEOUT` cycles after entry into WAIT_ACK.

## Test plan

- Single request: reset, then `irq_in` = 4'b0100 for 1 cycle.
  - `pending` = 4'b0100, then `ext_int3` is high 2 cycles later for 2 cycles, with `active_id` = 3.
  - `reti` pulse: `active_id` = 0 one cycle later, then IDLE after the 2-cycle gap.
- Priority: rises on sources 4 and 2 in the same cycle.
  - Source 2 is served first.
  - Source 4 is granted only after `reti` plus the gap; `pending` = 4'b1000 in between.
- Overrun: while source 1 is pending and masked, pulse `irq_in[0]` three more times.
  - `overrun_cnt` = 3.
  - 260 further pulses saturate it at 255.
  - `clr_status` sets it to 0.
- Mask: source 2 is masked and pending, and stays ungranted for 100 cycles.
  - Unmasking it grants it 1 cycle later.
- Timeout: `ACK_TIMEOUT` = 20, grant source 1 and never assert `reti`.
  - `ack_timeout` = 1, 20 cycles after the pulse ends.
  - The next pending source is served after the gap.
- Async reset: assert `reset` mid-PULSE, between clock edges.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, no stale grant occurs.
